// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer with run/halt FSM, jumps, call/return stack and sticky stack-error flags
module fetch_seq #(
  parameter int ADDR_W = 7,
  parameter int OFF_W = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_address,
  input  logic              branch,
  input  logic              taken,
  input  logic [OFF_W-1:0]  offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] pc_n, pc_inc, off_x, top;
  logic ovf_n, unf_n, push, full, empty;
  assign pc_inc = pc + ADDR_W'(1);
  assign off_x = ADDR_W'($signed(offset));
  assign full = cnt == CW'(RAS_DEPTH);
  assign empty = cnt == '0;
  assign top = ras[IW'(cnt - CW'(1))];
  // Strobes are tested before their qualifiers so undriven qualifiers never reach pc.
  always_comb begin
    pc_n = pc;
    state_n = state;
    cnt_n = cnt;
    ovf_n = ras_overflow;
    unf_n = ras_underflow;
    push = 1'b0;
    if (start) begin
      pc_n = start_address;
      state_n = RUN;
      cnt_n = '0;
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end else if (state == HALT) begin
      if (resume) begin
        pc_n = pc_inc;
        state_n = RUN;
      end
    end else if (state == RUN) begin
      if (halt) state_n = HALT;
      else if (ret) begin
        pc_n = empty ? pc_inc : top;
        cnt_n = empty ? cnt : cnt - CW'(1);
        unf_n = ras_underflow | empty;
      end else if (call) begin
        pc_n = target;
        push = !full;
        cnt_n = full ? cnt : cnt + CW'(1);
        ovf_n = ras_overflow | full;
      end else if (jump) pc_n = target;
      else if (branch && taken) pc_n = pc + off_x;
      else pc_n = pc_inc;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
      state <= IDLE;
      running <= 1'b0;
      cnt <= '0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc <= pc_n;
      state <= state_n;
      running <= state_n == RUN;
      cnt <= cnt_n;
      ras_overflow <= ovf_n;
      ras_underflow <= unf_n;
    end
  end
  always_ff @(posedge clock) if (push) ras[IW'(cnt)] <= pc_inc;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized scoreboard bench for fetch_seq against a queue-based reference model
module tb_fetch_seq;
  localparam int AW = 7, OW = 5, D = 4, M = 1 << AW;
  logic clock = 0, reset = 1;
  logic start = 0, branch = 0, taken = 0, jump = 0, call = 0, ret = 0, halt = 0, resume = 0;
  logic [AW-1:0] start_address = '0, target = '0;
  logic [OW-1:0] offset = '0;
  logic [AW-1:0] pc;
  logic running, ras_overflow, ras_underflow;
  int vectors = 0, miscompares = 0;
  logic [AW+2:0] exp_q[$];
  int m_pc, m_st;
  int m_ras[$];
  bit m_ovf, m_unf;

  fetch_seq #(.ADDR_W(AW), .OFF_W(OW), .RAS_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start(start), .start_address(start_address),
    .branch(branch), .taken(taken), .offset(offset), .jump(jump), .target(target),
    .call(call), .ret(ret), .halt(halt), .resume(resume), .pc(pc), .running(running),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow));

  always #5 clock = ~clock;

  function automatic logic [AW+2:0] m_out();
    return {AW'(m_pc), m_st == 1, m_ovf, m_unf};
  endfunction

  function automatic void m_reset();
    m_pc = 0; m_st = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
  endfunction

  task automatic check(input string name, input logic [AW+2:0] got, input logic [AW+2:0] e);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got pc=%0d run=%b ovf=%b unf=%b, expected pc=%0d run=%b ovf=%b unf=%b",
               name, $time, got[AW+2:3], got[2], got[1], got[0], e[AW+2:3], e[2], e[1], e[0]);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) check("pc_seq", {pc, running, ras_overflow, ras_underflow}, exp_q.pop_front());
  end

  // Model states: 0 idle, 1 run, 2 halt
  task automatic step(input bit st, input int sa, input bit br, input bit tk, input int off,
                      input bit jp, input int tg, input bit cl, input bit rt, input bit hl, input bit rs);
    @(negedge clock);
    start = st; start_address = st ? AW'(sa) : 'x;
    branch = br; taken = br ? tk : 1'bx; offset = br ? OW'(off) : 'x;
    jump = jp; call = cl; target = (jp || cl) ? AW'(tg) : 'x;
    ret = rt; halt = hl; resume = rs;
    if (st) begin
      m_pc = sa % M; m_st = 1; m_ras.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_st == 2) begin
      if (rs) begin m_pc = (m_pc + 1) % M; m_st = 1; end
    end else if (m_st == 1) begin
      if (hl) m_st = 2;
      else if (rt) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = (m_pc + 1) % M; m_unf = 1; end
      end else if (cl) begin
        if (m_ras.size() < D) m_ras.push_back((m_pc + 1) % M);
        else m_ovf = 1;
        m_pc = tg % M;
      end else if (jp) m_pc = tg % M;
      else if (br && tk) begin
        int s = off % (1 << OW);
        if (s >= (1 << (OW - 1))) s -= (1 << OW);
        m_pc = ((m_pc + s) % M + M) % M;
      end else m_pc = (m_pc + 1) % M;
    end
    exp_q.push_back(m_out());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clock);
    start = 0; branch = 0; jump = 0; call = 0; ret = 0; halt = 0; resume = 0;
    #2 reset = 1;
    #1 m_reset();
    check("async_reset", {pc, running, ras_overflow, ras_underflow}, m_out());
    @(negedge clock) reset = 0;
  endtask

  initial begin
    m_reset();
    #2 check("reset", {pc, running, ras_overflow, ras_underflow}, m_out());
    @(negedge clock) reset = 0;
    step(0, 0, 0, 0, 0, 1, 99, 0, 0, 0, 0);
    step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    step(0, 0, 1, 1, -5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 40, 1, 0, 0, 0);
    idle(); idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 20 + 10 * i, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 2, 1, 1, -5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, -5, 0, 0, 0, 0, 0, 0);
    step(1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(); idle(); idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      step($urandom_range(0, 99) < 3, $urandom_range(0, M - 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, (1 << OW) - 1),
           $urandom_range(0, 5) == 0, $urandom_range(0, M - 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
    end
    step(1, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 60 + i, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    mid_reset();
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    start = 0; branch = 0; jump = 0; call = 0; ret = 0; halt = 0; resume = 0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised next-generation instruction fetch sequencer that owns the program counter register internally; no separate PC module.
- Adds four things over the plain fetch/PC pair: a run/halt state machine with resume, absolute jumps, call/return via an internal return-address stack (RAS), and sticky stack-error flags.
- Sits between control decode and instruction memory. `pc` drives the instruction-memory address directly.

Parameters:
- ADDR_W, 7, width of program counter and all addresses
- OFF_W, 5, width of the signed relative branch offset
- RAS_DEPTH, 4, return-address stack entries (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  load start_address into pc and enter RUN
- start_address  in  ADDR_W  program entry point
- branch  in  1  current instruction is a conditional relative branch
- taken  in  1  branch condition true (qualifies branch only)
- offset  in  OFF_W  signed relative offset from current pc
- jump  in  1  absolute jump to target
- target  in  ADDR_W  absolute destination for jump/call
- call  in  1  push pc+1, then go to target
- ret  in  1  pop RAS into pc
- halt  in  1  stop fetching; pc holds
- resume  in  1  leave HALT and continue at pc+1
- pc  out  ADDR_W  current fetch address (registered)
- running  out  1  high in RUN state
- ras_overflow  out  1  sticky: call attempted with RAS full
- ras_underflow  out  1  sticky: ret attempted with RAS empty

Behaviour:
- Reset (async, any time, including mid-call): pc=0, state=IDLE, running=0, RAS empty (count=0), both error flags=0. Takes effect immediately, not at the next edge.
- States:
  - IDLE: pc holds. start -> RUN, pc<=start_address. All other inputs ignored.
  - RUN: pc updates every edge per the priority list below. halt -> HALT.
  - HALT: pc holds. resume -> RUN with pc<=pc+1. start -> RUN with pc<=start_address.
- start in any state: pc<=start_address, state<=RUN, RAS emptied, error flags cleared. start has the highest priority below reset.
- RUN next-pc priority, highest first (one action per cycle):
  1. halt: pc holds, state<=HALT.
  2. ret:
     - RAS non-empty: pc<=top entry, pop.
     - RAS empty: pc<=pc+1, ras_underflow<=1.
  3. call:
     - RAS not full: push pc+1, pc<=target.
     - RAS full: pc<=target, no push, RAS unchanged, ras_overflow<=1.
  4. jump: pc<=target.
  5. branch & taken: pc<=pc+sign_extend(offset).
  6. otherwise (including branch & !taken): pc<=pc+1.
- Arithmetic: all pc math is modulo 2^ADDR_W.
  - pc+1 wraps from 2^ADDR_W-1 to 0.
  - Offset is sign-extended to ADDR_W before the add. Negative results wrap, e.g. pc=2, offset=-5 -> 125 at ADDR_W=7.
- Latency: the one-cycle update; the new pc is visible after the clock edge where the control inputs are sampled.
- RAS:
  - LIFO of ADDR_W-bit entries with a count from 0 to RAS_DEPTH.
  - Push and pop never happen in the same cycle; ret beats call.
  - Pushed value is the pc+1 of the call instruction.
- Error flags are sticky until reset or start.
- resume outside HALT, and halt outside RUN, are ignored.
- Combinational inputs (branch, taken, offset, target) may be X/Z when their qualifying strobe is low. They must not propagate into pc.

Test Plan:
- Reset then start=1, start_address=10 for one cycle -> pc=10, running=1; next 2 edges -> pc=11, then 12.
- pc=12: branch=1, taken=1, offset=-5 -> pc=7. Then branch=1, taken=0 -> pc=8.
- pc=8: call, target=40 -> pc=40. Two edges later pc=42: ret -> pc=9.
- Stack limits:
  - Five consecutive calls (RAS_DEPTH=4) -> fifth raises ras_overflow=1 and still jumps to target.
  - Then five rets -> first four return in LIFO order; fifth sets ras_underflow=1 and gives pc+1.
- pc=127: increment -> pc=0. Separately, pc=30: halt -> pc stays 30 for 3 cycles with running=0; resume -> pc=31, running=1.
- Assert reset mid-run between clock edges -> pc=0 immediately; then start=1 -> ras_overflow and ras_underflow read 0.
